nibble_serial_subtractor: RTL

- Multi-cycle subtractor for the processor datapath: computes DIFF = IN0 - IN1 - BIN over WIDTH bits.
- Processes one 4-bit slice per clock, LSB nibble first. Each slice is a 4-bit adder fed with the inverted subtrahend, and the carry/borrow is registered between slices.
- Sits beside the ALU for area-constrained subtract and compare ops; uses a start/busy/done handshake with the control unit.

---
 rtl/nibble_serial_subtractor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: DIFF = IN0 - IN1 - BIN, one 4-bit slice per clock, LSB first.
// Define ADD_MODE_EN to add an ADD input that selects IN0 + IN1 + BIN instead.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT,
    output logic             ZERO,
    output logic             OVF
`ifdef ADD_MODE_EN
    ,
    input  logic             ADD
`endif
);

    localparam int N   = WIDTH / 4;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [K_W-1:0]   k;
    logic             carry;
    logic             add_reg;
    logic             add_in;
    logic             accept;
    logic             last;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [4:0]       sum;

`ifdef ADD_MODE_EN
    assign add_in = ADD;
`else
    assign add_in = 1'b0;
`endif

    assign accept = START && (state != ST_RUN);
    assign last   = (state == ST_RUN) && (k == K_W'(N - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (START) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = START ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == ST_RUN);
        DONE = (state == ST_DONE);
    end

    // Select the active slice and merge its sum into the partial result.
    always_comb begin
        slice_a   = 4'd0;
        slice_b   = 4'd0;
        work_next = work;
        for (int i = 0; i < N; i++) begin
            if (k == K_W'(i)) begin
                slice_a = a_reg[4*i +: 4];
                slice_b = b_reg[4*i +: 4];
            end
        end
        sum = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, carry};
        for (int i = 0; i < N; i++) begin
            if (k == K_W'(i)) begin
                work_next[4*i +: 4] = sum[3:0];
            end
        end
    end

    // b_reg holds the effective addend (IN1 inverted when subtracting), so one
    // overflow rule covers both modes: equal addend signs, differing result sign.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg   <= '0;
            b_reg   <= '0;
            work    <= '0;
            k       <= '0;
            carry   <= 1'b0;
            add_reg <= 1'b0;
            DIFF    <= '0;
            BOUT    <= 1'b0;
            ZERO    <= 1'b0;
            OVF     <= 1'b0;
        end else if (accept) begin
            a_reg   <= IN0;
            b_reg   <= add_in ? IN1 : ~IN1;
            carry   <= add_in ? BIN : ~BIN;
            add_reg <= add_in;
            work    <= '0;
            k       <= '0;
        end else if (state == ST_RUN) begin
            work  <= work_next;
            carry <= sum[4];
            k     <= last ? '0 : k + K_W'(1);
            if (last) begin
                DIFF <= work_next;
                BOUT <= add_reg ? sum[4] : ~sum[4];
                ZERO <= (work_next == '0);
                OVF  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (work_next[WIDTH-1] != a_reg[WIDTH-1]);
            end
        end
    end

endmodule
